// File: rtl/sort_pkg.sv
// -----------------------------------------------------------------------------
// sort_pkg
// Shared types and limits for the sort_engine accelerator.
//   state_t  : controller states (IDLE waits for loads/start, SORT runs phases)
//   parity_t : which neighbour pairs the current phase compares
//   Limits   : legal DEPTH range and default geometry
// Optional feature macro used by the engine: SORT_EARLY_EXIT_EN
// -----------------------------------------------------------------------------
package sort_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SORT = 1'b1
   } state_t;

   typedef enum logic {
      EVEN = 1'b0,
      ODD  = 1'b1
   } parity_t;

   localparam int SORT_MIN_DEPTH = 2;
   localparam int SORT_MAX_DEPTH = 256;
   localparam int SORT_DEF_WIDTH = 32;
   localparam int SORT_DEF_DEPTH = 8;

endpackage

// File: rtl/sort_cmp_swap.sv
// -----------------------------------------------------------------------------
// sort_cmp_swap
// One compare-exchange cell of the odd-even transposition network.
// Ports:
//   a, b        in  WIDTH  lower-index and higher-index element
//   descending  in  1      0 = ascending order, 1 = descending order
//   lo, hi      out WIDTH  values destined for the lower / higher index
//   swapped     out 1      the pair is out of order and was exchanged
// Compare is unsigned; equal values never swap so equal pairs stay put.
// -----------------------------------------------------------------------------
module sort_cmp_swap
   import sort_pkg::*;
#(
   parameter int WIDTH = SORT_DEF_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             descending,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi,
   output logic             swapped
);

   // A pair is out of order when the lower slot holds the "later" value for
   // the selected direction; strict compares keep equal values in place.
   assign swapped = descending ? (a < b) : (a > b);
   assign lo      = swapped ? b : a;
   assign hi      = swapped ? a : b;

endmodule

// File: rtl/sort_engine.sv
// -----------------------------------------------------------------------------
// sort_engine
// In-place odd-even transposition sorter for DEPTH words of WIDTH bits.
// Loaded through a write port, sorted on command (one phase per cycle) and
// read back through a combinational read port.
// Ports:
//   clk          in  1      rising-edge clock
//   rst_n        in  1      synchronous active-low reset (aborts a sort)
//   wr_en        in  1      write strobe, honoured only while idle
//   wr_addr      in  IDX_W  write index (indices >= DEPTH are ignored)
//   wr_data      in  WIDTH  write data
//   start        in  1      sort request, honoured only while idle
//   descending   in  1      order select, captured with start
//   rd_addr      in  IDX_W  read index
//   rd_data      out WIDTH  array[rd_addr], combinational
//   busy         out 1      high while sorting
//   done         out 1      one-cycle pulse at sort completion
//   phase_count  out CNT_W  phases run by the last completed sort
// Optional feature: define SORT_EARLY_EXIT_EN to stop once two consecutive
// phases make no swap; otherwise every sort runs exactly DEPTH phases.
// -----------------------------------------------------------------------------
module sort_engine
   import sort_pkg::*;
#(
   parameter  int WIDTH = SORT_DEF_WIDTH,
   parameter  int DEPTH = SORT_DEF_DEPTH,
   localparam int IDX_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             start,
   input  logic             descending,
   input  logic [IDX_W-1:0] rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] phase_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   state_t           r_state;
   state_t           w_nextState;
   parity_t          r_parity;
   logic             r_desc;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_phaseCount;
   logic             r_done;

   logic [WIDTH-1:0] w_lo [DEPTH-1];
   logic [WIDTH-1:0] w_hi [DEPTH-1];
   logic [DEPTH-2:0] w_swapped;
   logic [DEPTH-2:0] w_pairEn;
   logic [WIDTH-1:0] w_next [DEPTH];
   logic [CNT_W-1:0] w_cntNext;
   logic             w_lastPhase;
   logic             w_earlyStop;
   logic             w_wrAddrOk;
   logic             w_rdAddrOk;

`ifdef SORT_EARLY_EXIT_EN
   logic             r_prevSwap;
   logic             w_anySwap;
`endif

   // One compare-exchange cell per neighbour pair. Pair p joins even phases
   // when p is even and odd phases when p is odd, so active pairs never share
   // an element and the end element of an odd-length array idles in one phase.
   for (genvar g = 0; g < DEPTH - 1; g++) begin : g_cell
      sort_cmp_swap #(.WIDTH(WIDTH)) u_cell (
         .a          (r_mem[g]),
         .b          (r_mem[g+1]),
         .descending (r_desc),
         .lo         (w_lo[g]),
         .hi         (w_hi[g]),
         .swapped    (w_swapped[g])
      );
      assign w_pairEn[g] = ((r_parity == ODD) == (g % 2 == 1));
   end

   // Next array contents for a sort phase: an element is rewritten only when
   // its pair is active this phase and actually needs exchanging.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         w_next[k] = r_mem[k];
      end
      for (int p = 0; p < DEPTH - 1; p++) begin
         if (w_pairEn[p] && w_swapped[p]) begin
            w_next[p]   = w_lo[p];
            w_next[p+1] = w_hi[p];
         end
      end
   end

`ifdef SORT_EARLY_EXIT_EN
   // The array is ordered once both parities have made a clean pass, i.e. this
   // phase and the previous one swapped nothing. The history flag is preset on
   // start so at least two phases always run.
   assign w_anySwap   = |(w_swapped & w_pairEn);
   assign w_earlyStop = !w_anySwap && !r_prevSwap;
`else
   assign w_earlyStop = 1'b0;
`endif

   assign w_cntNext  = r_cnt + 1'b1;
   assign w_wrAddrOk = ({1'b0, wr_addr} < (IDX_W+1)'(DEPTH));
   assign w_rdAddrOk = ({1'b0, rd_addr} < (IDX_W+1)'(DEPTH));

   // Controller next-state logic: IDLE moves to SORT on start; SORT returns to
   // IDLE at the edge that completes the final phase.
   always_comb begin
      w_nextState = r_state;
      w_lastPhase = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_nextState = SORT;
            end
         end
         SORT: begin
            w_lastPhase = (w_cntNext == CNT_W'(DEPTH)) || w_earlyStop;
            if (w_lastPhase) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // State register; reset aborts any sort in progress.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Array, phase bookkeeping and done pulse. In IDLE a write lands on the same
   // edge that accepts start, so the sort sees the updated array. In SORT all
   // port requests are ignored and one phase is applied per edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_mem[k] <= '0;
         end
         r_parity     <= EVEN;
         r_desc       <= 1'b0;
         r_cnt        <= '0;
         r_phaseCount <= '0;
         r_done       <= 1'b0;
`ifdef SORT_EARLY_EXIT_EN
         r_prevSwap   <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         if (r_state == IDLE) begin
            if (wr_en && w_wrAddrOk) begin
               r_mem[wr_addr] <= wr_data;
            end
            if (start) begin
               r_desc   <= descending;
               r_cnt    <= '0;
               r_parity <= EVEN;
`ifdef SORT_EARLY_EXIT_EN
               r_prevSwap <= 1'b1;
`endif
            end
         end else begin
            for (int k = 0; k < DEPTH; k++) begin
               r_mem[k] <= w_next[k];
            end
            r_parity <= (r_parity == EVEN) ? ODD : EVEN;
            r_cnt    <= w_cntNext;
`ifdef SORT_EARLY_EXIT_EN
            r_prevSwap <= w_anySwap;
`endif
            if (w_lastPhase) begin
               r_done       <= 1'b1;
               r_phaseCount <= w_cntNext;
            end
         end
      end
   end

   assign rd_data     = w_rdAddrOk ? r_mem[rd_addr] : '0;
   assign busy        = (r_state == SORT);
   assign done        = r_done;
   assign phase_count = r_phaseCount;

endmodule

// File: tb/tb_sort_engine.sv
// -----------------------------------------------------------------------------
// tb_sort_engine
// Self-checking bench for sort_engine. Two instances are exercised: DEPTH=5
// (index 0) and DEPTH=8 (index 1), sharing clock and reset. Expected array
// contents come from a reference sort and are queued when a sort is launched,
// then popped as the result is read back.
// -----------------------------------------------------------------------------
module tb_sort_engine;

   localparam int W = 32;

`ifdef SORT_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   typedef logic [W-1:0] arr_t [8];

   logic         clk;
   logic         rst_n;
   logic         wrEn   [2];
   logic [2:0]   wrAddr [2];
   logic [W-1:0] wrData [2];
   logic         start  [2];
   logic         desc   [2];
   logic [2:0]   rdAddr [2];
   logic [W-1:0] rdData [2];
   logic         busy   [2];
   logic         done   [2];
   logic [2:0]   pc5;
   logic [3:0]   pc8;

   int           checkCount;
   int           passCount;
   logic [W-1:0] expQ [$];

   sort_engine #(.WIDTH(W), .DEPTH(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .wr_en(wrEn[0]), .wr_addr(wrAddr[0]),
      .wr_data(wrData[0]), .start(start[0]), .descending(desc[0]),
      .rd_addr(rdAddr[0]), .rd_data(rdData[0]), .busy(busy[0]),
      .done(done[0]), .phase_count(pc5)
   );

   sort_engine #(.WIDTH(W), .DEPTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .wr_en(wrEn[1]), .wr_addr(wrAddr[1]),
      .wr_data(wrData[1]), .start(start[1]), .descending(desc[1]),
      .rd_addr(rdAddr[1]), .rd_data(rdData[1]), .busy(busy[1]),
      .done(done[1]), .phase_count(pc8)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference sort: plain insertion sort, unsigned, stable.
   function automatic arr_t sortModel(input arr_t vals, input int n, input logic dsc);
      arr_t t;
      logic [W-1:0] key;
      int j;
      t = vals;
      for (int i = 1; i < n; i++) begin
         key = t[i];
         j = i - 1;
         while (j >= 0 && (dsc ? (t[j] < key) : (t[j] > key))) begin
            t[j+1] = t[j];
            j--;
         end
         t[j+1] = key;
      end
      return t;
   endfunction

   // Number of phases a sort takes: n in full mode; with early exit, the first
   // phase that follows another swap-free phase (never before phase 2).
   function automatic int modelPhases(input arr_t vals, input int n, input logic dsc);
      arr_t t;
      logic [W-1:0] tmp;
      bit prev;
      bit cur;
      t = vals;
      prev = 1'b1;
      for (int p = 0; p < n; p++) begin
         cur = 1'b0;
         for (int i = p % 2; i + 1 < n; i += 2) begin
            if (dsc ? (t[i] < t[i+1]) : (t[i] > t[i+1])) begin
               tmp = t[i];
               t[i] = t[i+1];
               t[i+1] = tmp;
               cur = 1'b1;
            end
         end
         if (EARLY && !cur && !prev) return p + 1;
         prev = cur;
      end
      return n;
   endfunction

   task automatic pushExpected(input arr_t vals, input int n, input logic dsc);
      arr_t s;
      s = sortModel(vals, n, dsc);
      for (int i = 0; i < n; i++) expQ.push_back(s[i]);
   endtask

   task automatic loadArray(input int d, input arr_t vals, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         wrEn[d]   = 1'b1;
         wrAddr[d] = 3'(i);
         wrData[d] = vals[i];
      end
      @(negedge clk);
      wrEn[d] = 1'b0;
   endtask

   // Launch a sort and count edges after the start edge until done is seen.
   // lat stays -1 if done never arrives within the budget.
   task automatic runSort(input int d, input logic dsc, input bit flipMid, output int lat);
      @(negedge clk);
      start[d] = 1'b1;
      desc[d]  = dsc;
      @(negedge clk);
      start[d] = 1'b0;
      lat = -1;
      for (int c = 1; c <= 300; c++) begin
         @(posedge clk);
         #1;
         if (done[d]) begin
            lat = c;
            break;
         end
         if (flipMid && c == 1) desc[d] = ~dsc;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkCount++;
      if (busy[1] !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy[1]);
      else passCount++;
      checkCount++;
      if (done[1] !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done[1]);
      else passCount++;
      checkCount++;
      if (pc8 !== 4'd0) $display("[TB] FAIL reset_pc8: got %0d expected 0", pc8);
      else passCount++;
      checkCount++;
      if (pc5 !== 3'd0) $display("[TB] FAIL reset_pc5: got %0d expected 0", pc5);
      else passCount++;
      for (int i = 0; i < 8; i++) begin
         rdAddr[1] = 3'(i);
         #1;
         checkCount++;
         if (rdData[1] !== '0) $display("[TB] FAIL reset_data[%0d]: got %h expected 0", i, rdData[1]);
         else passCount++;
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_ascending();
      arr_t v;
      int lat;
      int expLat;
      logic [W-1:0] e;
      v = '{32'd9, 32'd3, 32'd7, 32'd1, 32'd5, 32'd0, 32'd0, 32'd0};
      loadArray(0, v, 5);
      pushExpected(v, 5, 1'b0);
      expLat = modelPhases(v, 5, 1'b0);
      runSort(0, 1'b0, 1'b0, lat);
      checkCount++;
      if (lat !== expLat) $display("[TB] FAIL asc5_latency: got %0d expected %0d", lat, expLat);
      else passCount++;
      checkCount++;
      if (int'(pc5) !== expLat) $display("[TB] FAIL asc5_phase_count: got %0d expected %0d", pc5, expLat);
      else passCount++;
      for (int i = 0; i < 5; i++) begin
         rdAddr[0] = 3'(i);
         #1;
         e = expQ.pop_front();
         checkCount++;
         if (rdData[0] !== e) $display("[TB] FAIL asc5_data[%0d]: got %h expected %h", i, rdData[0], e);
         else passCount++;
      end
   endtask

   task automatic test_descending();
      arr_t v;
      int lat;
      int expLat;
      logic [W-1:0] e;
      v = '{32'd9, 32'd3, 32'd7, 32'd1, 32'd5, 32'd0, 32'd0, 32'd0};
      loadArray(0, v, 5);
      pushExpected(v, 5, 1'b1);
      expLat = modelPhases(v, 5, 1'b1);
      runSort(0, 1'b1, 1'b1, lat);
      checkCount++;
      if (lat !== expLat) $display("[TB] FAIL desc5_latency: got %0d expected %0d", lat, expLat);
      else passCount++;
      for (int i = 0; i < 5; i++) begin
         rdAddr[0] = 3'(i);
         #1;
         e = expQ.pop_front();
         checkCount++;
         if (rdData[0] !== e) $display("[TB] FAIL desc5_data[%0d]: got %h expected %h", i, rdData[0], e);
         else passCount++;
      end
   endtask

   task automatic test_unsigned();
      arr_t v;
      int lat;
      int expLat;
      logic [W-1:0] e;
      v = '{32'hFFFF_FFFF, 32'd0, 32'd4, 32'h8000_0000,
            32'd4, 32'h7FFF_FFFF, 32'd1, 32'h1234_5678};
      loadArray(1, v, 8);
      pushExpected(v, 8, 1'b0);
      expLat = modelPhases(v, 8, 1'b0);
      runSort(1, 1'b0, 1'b0, lat);
      checkCount++;
      if (lat !== expLat) $display("[TB] FAIL unsigned8_latency: got %0d expected %0d", lat, expLat);
      else passCount++;
      checkCount++;
      if (int'(pc8) !== expLat) $display("[TB] FAIL unsigned8_phase_count: got %0d expected %0d", pc8, expLat);
      else passCount++;
      for (int i = 0; i < 8; i++) begin
         rdAddr[1] = 3'(i);
         #1;
         e = expQ.pop_front();
         checkCount++;
         if (rdData[1] !== e) $display("[TB] FAIL unsigned8_data[%0d]: got %h expected %h", i, rdData[1], e);
         else passCount++;
      end
   endtask

   task automatic test_early_exit();
      arr_t v;
      int lat;
      int expLat;
      logic [W-1:0] e;
      v = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
      expLat = EARLY ? 2 : 8;
      loadArray(1, v, 8);
      pushExpected(v, 8, 1'b0);
      runSort(1, 1'b0, 1'b0, lat);
      checkCount++;
      if (lat !== expLat) $display("[TB] FAIL sorted8_latency: got %0d expected %0d", lat, expLat);
      else passCount++;
      checkCount++;
      if (int'(pc8) !== expLat) $display("[TB] FAIL sorted8_phase_count: got %0d expected %0d", pc8, expLat);
      else passCount++;
      for (int i = 0; i < 8; i++) begin
         rdAddr[1] = 3'(i);
         #1;
         e = expQ.pop_front();
         checkCount++;
         if (rdData[1] !== e) $display("[TB] FAIL sorted8_data[%0d]: got %h expected %h", i, rdData[1], e);
         else passCount++;
      end
   endtask

   task automatic test_busy_ignore();
      arr_t v;
      int expLat;
      int doneCount;
      int firstDone;
      logic [W-1:0] e;
      v = '{32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
      loadArray(1, v, 8);
      pushExpected(v, 8, 1'b0);
      expLat = modelPhases(v, 8, 1'b0);
      doneCount = 0;
      firstDone = -1;
      @(negedge clk);
      start[1] = 1'b1;
      desc[1]  = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) start[1] = 1'b0;
         if (c == 3) begin
            wrEn[1]   = 1'b1;
            wrAddr[1] = 3'd0;
            wrData[1] = 32'hDEAD;
            start[1]  = 1'b1;
         end
         if (c == 4) begin
            wrEn[1]  = 1'b0;
            start[1] = 1'b0;
         end
         @(posedge clk);
         #1;
         if (done[1]) begin
            doneCount++;
            if (firstDone < 0) firstDone = c;
         end
      end
      checkCount++;
      if (doneCount !== 1) $display("[TB] FAIL busy_done_pulses: got %0d expected 1", doneCount);
      else passCount++;
      checkCount++;
      if (firstDone !== expLat) $display("[TB] FAIL busy_latency: got %0d expected %0d", firstDone, expLat);
      else passCount++;
      for (int i = 0; i < 8; i++) begin
         rdAddr[1] = 3'(i);
         #1;
         e = expQ.pop_front();
         checkCount++;
         if (rdData[1] !== e) $display("[TB] FAIL busy_data[%0d]: got %h expected %h", i, rdData[1], e);
         else passCount++;
      end
   endtask

   task automatic test_reset_mid();
      arr_t v;
      int doneSeen;
      v = '{32'd5, 32'd1, 32'd4, 32'd2, 32'd8, 32'd6, 32'd7, 32'd3};
      loadArray(1, v, 8);
      @(negedge clk);
      start[1] = 1'b1;
      desc[1]  = 1'b0;
      @(negedge clk);
      start[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkCount++;
      if (busy[1] !== 1'b1) $display("[TB] FAIL midreset_busy_before: got %b expected 1", busy[1]);
      else passCount++;
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkCount++;
      if (busy[1] !== 1'b0) $display("[TB] FAIL midreset_busy_after: got %b expected 0", busy[1]);
      else passCount++;
      doneSeen = done[1] ? 1 : 0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (done[1]) doneSeen++;
      end
      checkCount++;
      if (doneSeen !== 0) $display("[TB] FAIL midreset_done_pulses: got %0d expected 0", doneSeen);
      else passCount++;
      for (int i = 0; i < 8; i++) begin
         rdAddr[1] = 3'(i);
         #1;
         checkCount++;
         if (rdData[1] !== '0) $display("[TB] FAIL midreset_data[%0d]: got %h expected 0", i, rdData[1]);
         else passCount++;
      end
   endtask

   task automatic test_back_to_back();
      arr_t v;
      arr_t s;
      int lat1;
      int lat2;
      int expLat1;
      int expLat2;
      logic [W-1:0] e;
      v = '{32'd3, 32'd9, 32'd2, 32'd7, 32'd0, 32'd6, 32'd1, 32'd5};
      s = sortModel(v, 8, 1'b0);
      expLat1 = modelPhases(v, 8, 1'b0);
      expLat2 = modelPhases(s, 8, 1'b1);
      loadArray(1, v, 8);
      pushExpected(v, 8, 1'b1);
      runSort(1, 1'b0, 1'b0, lat1);
      runSort(1, 1'b1, 1'b0, lat2);
      checkCount++;
      if (lat1 !== expLat1) $display("[TB] FAIL b2b_latency1: got %0d expected %0d", lat1, expLat1);
      else passCount++;
      checkCount++;
      if (lat2 !== expLat2) $display("[TB] FAIL b2b_latency2: got %0d expected %0d", lat2, expLat2);
      else passCount++;
      for (int i = 0; i < 8; i++) begin
         rdAddr[1] = 3'(i);
         #1;
         e = expQ.pop_front();
         checkCount++;
         if (rdData[1] !== e) $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", i, rdData[1], e);
         else passCount++;
      end
   endtask

   // Hard stop in case a wait escapes its budget.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Test sequence.
   initial begin
      checkCount = 0;
      passCount  = 0;
      for (int d = 0; d < 2; d++) begin
         wrEn[d]   = 1'b0;
         wrAddr[d] = '0;
         wrData[d] = '0;
         start[d]  = 1'b0;
         desc[d]   = 1'b0;
         rdAddr[d] = '0;
      end
      test_reset();
      test_ascending();
      test_descending();
      test_unsigned();
      test_early_exit();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
